// File: rtl/pcie_tx_arbiter.sv
// Round-robin packet arbiter sharing one Avalon-ST TX port among NUM_REQ TLP sources.
// Grants are locked SOP..EOP; stray beats seen while idle are discarded and counted.
module pcie_tx_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 64
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          my_id_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_REQ-1:0]            in_valid,
   input  logic [NUM_REQ-1:0]            in_sop,
   input  logic [NUM_REQ-1:0]            in_eop,
   output logic [NUM_REQ-1:0]            in_ready,
   output logic [DATA_WIDTH-1:0]         tx_st_data,
   output logic                          tx_st_valid,
   output logic                          tx_st_sop,
   output logic                          tx_st_eop,
   input  logic                          tx_st_ready,
   output logic [NUM_REQ-1:0]            grant,
   output logic                          busy,
   output logic [15:0]                   drop_count
);

   localparam int IW = $clog2(NUM_REQ);

   typedef enum logic {
      S_IDLE,
      S_PKT
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_REQ-1:0]      grant_q, grant_d;
   logic [IW-1:0]           last_q, last_d;
   logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
   logic                    tx_valid_q, tx_valid_d;
   logic                    tx_sop_q, tx_sop_d;
   logic                    tx_eop_q, tx_eop_d;
   logic [15:0]             drop_q, drop_d;

   logic                    stage_ready;
   logic [NUM_REQ-1:0]      elig;
   logic [NUM_REQ-1:0]      rdy_c;
   logic                    found_hi, found_lo;
   logic [IW-1:0]           hi_idx, lo_idx, pick_idx;
   logic [DATA_WIDTH-1:0]   sel_data;
   logic                    sel_sop, sel_eop;

   assign stage_ready = !tx_valid_q | tx_st_ready;
   assign elig        = in_valid & in_sop;

   // Rotating priority: first eligible above last, else first eligible from 0.
   always_comb begin
      found_hi = 1'b0;
      found_lo = 1'b0;
      hi_idx   = '0;
      lo_idx   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (elig[i] && !found_lo) begin
            found_lo = 1'b1;
            lo_idx   = IW'(i);
         end
         if (elig[i] && (i > int'(last_q)) && !found_hi) begin
            found_hi = 1'b1;
            hi_idx   = IW'(i);
         end
      end
      pick_idx = found_hi ? hi_idx : lo_idx;
   end

   always_comb begin
      sel_data = '0;
      sel_sop  = 1'b0;
      sel_eop  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_q[i]) begin
            sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
            sel_sop  = in_sop[i];
            sel_eop  = in_eop[i];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      last_d     = last_q;
      tx_data_d  = tx_data_q;
      tx_valid_d = tx_valid_q & !tx_st_ready;
      tx_sop_d   = tx_sop_q;
      tx_eop_d   = tx_eop_q;
      drop_d     = drop_q;
      rdy_c      = '0;
      unique case (state_q)
         S_IDLE: begin
            rdy_c = in_valid & ~in_sop;
            if (|rdy_c && drop_q != 16'hFFFF) begin
               drop_d = drop_q + 16'd1;
            end
            if (my_id_valid && |elig) begin
               state_d = S_PKT;
               last_d  = pick_idx;
               for (int i = 0; i < NUM_REQ; i++) begin
                  grant_d[i] = (pick_idx == IW'(i));
               end
            end
         end
         S_PKT: begin
            rdy_c = grant_q & {NUM_REQ{stage_ready}};
            if (|(rdy_c & in_valid)) begin
               tx_data_d  = sel_data;
               tx_valid_d = 1'b1;
               tx_sop_d   = sel_sop;
               tx_eop_d   = sel_eop;
               if (sel_eop) begin
                  state_d = S_IDLE;
                  grant_d = '0;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         grant_q    <= '0;
         last_q     <= IW'(NUM_REQ - 1);
         tx_data_q  <= '0;
         tx_valid_q <= 1'b0;
         tx_sop_q   <= 1'b0;
         tx_eop_q   <= 1'b0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         tx_sop_q   <= tx_sop_d;
         tx_eop_q   <= tx_eop_d;
         drop_q     <= drop_d;
      end
   end

   assign in_ready    = reset ? '0 : rdy_c;
   assign tx_st_data  = tx_data_q;
   assign tx_st_valid = tx_valid_q;
   assign tx_st_sop   = tx_sop_q;
   assign tx_st_eop   = tx_eop_q;
   assign grant       = grant_q;
   assign busy        = (state_q == S_PKT);
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// Directed bench for pcie_tx_arbiter: vector table for a simple packet,
// hand-written sequences for round robin, gating, backpressure, drops and reset.
module tb_pcie_tx_arbiter;

   logic          clk;
   logic          reset;
   logic          my_id_valid;
   logic [191:0]  in_data;
   logic [2:0]    in_valid, in_sop, in_eop, in_ready;
   logic [63:0]   tx_st_data;
   logic          tx_st_valid, tx_st_sop, tx_st_eop, tx_st_ready;
   logic [2:0]    grant;
   logic          busy;
   logic [15:0]   drop_count;

   int checks;
   int failures;

   pcie_tx_arbiter #(.NUM_REQ(3), .DATA_WIDTH(64)) dut (
      .clk         (clk),
      .reset       (reset),
      .my_id_valid (my_id_valid),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_sop      (in_sop),
      .in_eop      (in_eop),
      .in_ready    (in_ready),
      .tx_st_data  (tx_st_data),
      .tx_st_valid (tx_st_valid),
      .tx_st_sop   (tx_st_sop),
      .tx_st_eop   (tx_st_eop),
      .tx_st_ready (tx_st_ready),
      .grant       (grant),
      .busy        (busy),
      .drop_count  (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        id;
      logic [2:0]  v, s, e;
      logic [63:0] d;
      logic        rdy;
      logic [2:0]  x_rdy, x_gnt;
      logic        x_busy, x_val, x_sop, x_eop;
      logic [63:0] x_data;
   } vec_t;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      in_valid = '0;
      in_sop = '0;
      in_eop = '0;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      vec_t tbl[5];
      checks = 0;
      failures = 0;
      reset = 1'b1;
      my_id_valid = 1'b0;
      in_data = '0;
      in_valid = 3'b111;
      in_sop = '0;
      in_eop = '0;
      tx_st_ready = 1'b1;

      tick();
      #1;
      chk("rst_in_ready", in_ready, 0);
      tick();
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_tx_valid", tx_st_valid, 0);
      chk("rst_tx_data", tx_st_data, 0);
      chk("rst_drop", drop_count, 0);
      reset = 1'b0;
      in_valid = '0;

      // single 3-beat packet from req0
      tbl[0] = '{1'b1, 3'b001, 3'b001, 3'b000, 64'hD0, 1'b1,
                 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
      tbl[1] = '{1'b1, 3'b001, 3'b001, 3'b000, 64'hD0, 1'b1,
                 3'b001, 3'b001, 1'b1, 1'b1, 1'b1, 1'b0, 64'hD0};
      tbl[2] = '{1'b1, 3'b001, 3'b000, 3'b000, 64'hD1, 1'b1,
                 3'b001, 3'b001, 1'b1, 1'b1, 1'b0, 1'b0, 64'hD1};
      tbl[3] = '{1'b1, 3'b001, 3'b000, 3'b001, 64'hD2, 1'b1,
                 3'b001, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 64'hD2};
      tbl[4] = '{1'b1, 3'b000, 3'b000, 3'b000, 64'hD3, 1'b1,
                 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0};
      for (int i = 0; i < 5; i++) begin
         my_id_valid = tbl[i].id;
         in_valid = tbl[i].v;
         in_sop = tbl[i].s;
         in_eop = tbl[i].e;
         in_data = {128'h0, tbl[i].d};
         tx_st_ready = tbl[i].rdy;
         #1;
         chk($sformatf("v%0d_in_ready", i), in_ready, tbl[i].x_rdy);
         tick();
         chk($sformatf("v%0d_grant", i), grant, tbl[i].x_gnt);
         chk($sformatf("v%0d_busy", i), busy, tbl[i].x_busy);
         chk($sformatf("v%0d_tx_valid", i), tx_st_valid, tbl[i].x_val);
         if (tbl[i].x_val) begin
            chk($sformatf("v%0d_tx_data", i), tx_st_data, tbl[i].x_data);
            chk($sformatf("v%0d_tx_sop", i), tx_st_sop, tbl[i].x_sop);
            chk($sformatf("v%0d_tx_eop", i), tx_st_eop, tbl[i].x_eop);
         end
      end

      // round robin of single-beat packets
      do_reset();
      my_id_valid = 1'b1;
      in_data = {64'hC2, 64'hC1, 64'hC0};
      in_valid = 3'b111;
      in_sop = 3'b111;
      in_eop = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick();
         chk($sformatf("rr%0d_grant", k), grant, 3'b001 << (k % 3));
         chk($sformatf("rr%0d_bubble", k), tx_st_valid, 0);
         tick();
         chk($sformatf("rr%0d_idle", k), grant, 0);
         chk($sformatf("rr%0d_valid", k), tx_st_valid, 1);
         chk($sformatf("rr%0d_data", k), tx_st_data, 64'hC0 + 64'(k % 3));
         chk($sformatf("rr%0d_sopeop", k), {tx_st_sop, tx_st_eop}, 2'b11);
      end

      // grant gating on my_id_valid
      do_reset();
      my_id_valid = 1'b0;
      in_data = {64'hA2, 64'hA1, 64'hA0};
      in_valid = 3'b010;
      in_sop = 3'b010;
      in_eop = 3'b010;
      for (int k = 0; k < 10; k++) begin
         #1;
         chk($sformatf("gate%0d_in_ready", k), in_ready, 0);
         tick();
         chk($sformatf("gate%0d_grant", k), grant, 0);
      end
      my_id_valid = 1'b1;
      tick();
      chk("gate_grant", grant, 3'b010);
      chk("gate_in_ready", in_ready, 3'b010);
      tick();
      chk("gate_tx_data", tx_st_data, 64'hA1);
      chk("gate_done", grant, 0);
      in_valid = '0;

      // backpressure mid-packet
      do_reset();
      in_valid = 3'b001;
      in_sop = 3'b001;
      in_eop = 3'b000;
      in_data = {128'h0, 64'hB0};
      tick();
      chk("bp_grant", grant, 3'b001);
      tick();
      chk("bp_b0", tx_st_data, 64'hB0);
      in_sop = 3'b000;
      in_data = {128'h0, 64'hB1};
      tick();
      chk("bp_b1", tx_st_data, 64'hB1);
      in_data = {128'h0, 64'hB2};
      tx_st_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk($sformatf("bp%0d_in_ready", k), in_ready, 0);
         tick();
         chk($sformatf("bp%0d_hold", k), {tx_st_valid, tx_st_data},
             {1'b1, 64'hB1});
      end
      tx_st_ready = 1'b1;
      #1;
      chk("bp_release_rdy", in_ready, 3'b001);
      tick();
      chk("bp_b2", {tx_st_valid, tx_st_data}, {1'b1, 64'hB2});
      in_data = {128'h0, 64'hB3};
      in_eop = 3'b001;
      tick();
      chk("bp_b3", {tx_st_valid, tx_st_eop, tx_st_data}, {2'b11, 64'hB3});
      chk("bp_end_grant", grant, 0);
      in_valid = '0;
      in_eop = '0;
      tick();
      chk("bp_drain", tx_st_valid, 0);

      // stray beats in IDLE
      do_reset();
      in_valid = 3'b100;
      in_sop = 3'b000;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk($sformatf("stray%0d_in_ready", k), in_ready, 3'b100);
         tick();
         chk($sformatf("stray%0d_drop", k), drop_count, 16'(k + 1));
         chk($sformatf("stray%0d_tx", k), {tx_st_valid, grant}, 0);
      end
      in_valid = '0;
      tick();
      chk("stray_hold", drop_count, 3);

      // reset mid-packet from req1
      in_data = {64'h0, 64'hE0, 64'h0};
      in_valid = 3'b010;
      in_sop = 3'b010;
      tick();
      chk("rmp_grant", grant, 3'b010);
      tick();
      chk("rmp_e0", tx_st_data, 64'hE0);
      in_sop = 3'b000;
      in_data = {64'h0, 64'hE1, 64'h0};
      tick();
      chk("rmp_e1", tx_st_data, 64'hE1);
      in_data = {64'h0, 64'hE2, 64'h0};
      reset = 1'b1;
      #1;
      chk("rmp_rst_in_ready", in_ready, 0);
      tick();
      reset = 1'b0;
      in_valid = '0;
      chk("rmp_tx_valid", tx_st_valid, 0);
      chk("rmp_grant0", grant, 0);
      chk("rmp_busy", busy, 0);
      chk("rmp_drop", drop_count, 0);
      in_data = {64'hF2, 64'hF1, 64'hF0};
      in_valid = 3'b110;
      in_sop = 3'b110;
      in_eop = 3'b110;
      tick();
      chk("rmp_regrant", grant, 3'b010);

      // drop counter saturation
      do_reset();
      in_valid = 3'b100;
      in_sop = 3'b000;
      repeat (65534) tick();
      chk("sat_fffe", drop_count, 16'hFFFE);
      tick();
      chk("sat_ffff", drop_count, 16'hFFFF);
      repeat (3) tick();
      chk("sat_hold", drop_count, 16'hFFFF);
      chk("sat_no_tx", tx_st_valid, 0);
      in_valid = '0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
